// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a single full-subtractor cell, a borrow flop and a valid/ready handshake.

module serial_borrow_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ br;
    assign bo = (~a & b) | (~(a ^ b) & br);
endmodule

module serial_borrow_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb, b_msb;
    logic             d_bit, bo_bit;
    logic             last;
    logic [WIDTH-1:0] res_next;

    serial_borrow_subtractor_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .br (br),
        .d  (d_bit),
        .bo (bo_bit)
    );

    assign last     = (cnt == CW'(WIDTH - 1));
    // the bit computed this cycle enters from the MSB side
    assign res_next = {d_bit, res_sr};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    br    <= bin;
                    cnt   <= '0;
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= bo_bit;
                    cnt    <= cnt + 1'b1;
                    res_sr <= res_next[WIDTH-1:1];
                    // result outputs only change when an operation completes
                    if (last) begin
                        diff <= res_next;
                        bout <= bo_bit;
                        ovf  <= (a_msb != b_msb) & (d_bit != a_msb);
                        zero <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Bit-serial subtractor computing a - b - bin.
- Processes one bit per clock, LSB first, over WIDTH cycles, using a single full-subtractor cell and a borrow flop.
- Valid/ready handshake on input and output; one operation in flight at a time.
- Area-optimised counterpart of the parallel ripple carry adder in the datapath library; used where a subtraction (compare/decrement) can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend (unsigned or two's complement)
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  unsigned borrow out; 1 iff a < b + bin
- ovf  output  1  signed overflow
- zero  output  1  diff == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; zero=0; internal shift registers, borrow flop and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a, b into shift registers, bin into the borrow flop, counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the result register from the MSB side.
  - counter increments each edge.
  - After the edge processing bit WIDTH-1: go to DONE.
  - The final borrow becomes bout.
- DONE:
  - out_valid=1; diff, bout, ovf and zero are stable and held.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]), using the captured copy of the a and b MSBs.
  - zero = (diff == 0).
  - On an edge with out_ready=1: go to IDLE; out_valid drops.
  - diff, bout, ovf and zero retain their values until the next DONE.
  - out_ready=0 holds DONE indefinitely.
- Latency:
  - Acceptance edge E0; out_valid rises after edge E0+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (no overlap; in_ready=0 in RUN and DONE).
- in_valid in RUN/DONE is ignored; the operands are not captured.
- a, b and bin need only be valid on the acceptance edge; later changes have no effect.
- out_ready is ignored outside DONE.
- Asynchronous reset mid-RUN or mid-DONE aborts the operation and no result is delivered. The first edge after rst_n rises may accept a new operation.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic: WIDTH=8, a=200, b=55, bin=0 → out_valid exactly 8 cycles after acceptance; diff=145, bout=0, ovf=0, zero=0.
- Unsigned borrow: a=5, b=10, bin=0 → diff=251 (0xFB), bout=1, ovf=0, zero=0.
- Signed overflow: a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1; then a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1.
- Borrow-in and zero: a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1, zero=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b → outputs unchanged, in_ready=0, no new capture. out_ready=1 → IDLE next cycle with in_ready=1.
- Reset mid-op: assert rst_n=0 after 3 RUN cycles → all outputs zero immediately, in_ready=1. Release and issue a=9, b=4 → diff=5 after 8 cycles.
